// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline stall/flush controller
package pipe_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, RELEASE} mem_state_t;
   localparam int REG_W           = 4;
   localparam int MEM_TIMEOUT_DEF = 64;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: bundle between pipeline stages and the stall/flush controller
interface pipe_hazard_ctrl_if
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
);
   logic [REG_W-1:0] id_src1, id_src2, exe_dest, mem_dest;
   logic             id_two_src, id_valid, exe_wb_en, mem_wb_en;
   logic             exe_branch_taken, mem_req, mem_ready;
   logic             pc_freeze, ifid_freeze, idex_bubble, ifid_flush, idex_flush;
   logic             pipe_freeze, sram_start, mem_err;
   logic [CNT_W-1:0] stall_cnt;
   modport master (
      output id_src1, id_src2, id_two_src, id_valid, exe_wb_en, mem_wb_en,
             exe_dest, mem_dest, exe_branch_taken, mem_req, mem_ready,
      input  pc_freeze, ifid_freeze, idex_bubble, ifid_flush, idex_flush,
             pipe_freeze, sram_start, mem_err, stall_cnt
   );
   modport slave (
      input  id_src1, id_src2, id_two_src, id_valid, exe_wb_en, mem_wb_en,
             exe_dest, mem_dest, exe_branch_taken, mem_req, mem_ready,
      output pc_freeze, ifid_freeze, idex_bubble, ifid_flush, idex_flush,
             pipe_freeze, sram_start, mem_err, stall_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// hazard_detect: RAW hazard between the ID sources and the EXE/MEM destinations (no forwarding)
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] i_id_src1,
   input  logic [REG_W-1:0] i_id_src2,
   input  logic             i_id_two_src,
   input  logic             i_id_valid,
   input  logic             i_exe_wb_en,
   input  logic [REG_W-1:0] i_exe_dest,
   input  logic             i_mem_wb_en,
   input  logic [REG_W-1:0] i_mem_dest,
   output logic             o_hazard
);
   logic w_src1_hit, w_src2_hit;
   assign w_src1_hit = (i_exe_wb_en && i_exe_dest == i_id_src1) || (i_mem_wb_en && i_mem_dest == i_id_src1);
   assign w_src2_hit = (i_exe_wb_en && i_exe_dest == i_id_src2) || (i_mem_wb_en && i_mem_dest == i_id_src2);
   assign o_hazard   = i_id_valid && (w_src1_hit || (i_id_two_src && w_src2_hit));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: freeze/bubble/flush control from RAW hazards, taken branches and SRAM accesses
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   pipe_hazard_ctrl_if.slave bus
);
   localparam int              TW   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TW-1:0]   LAST = TW'(MEM_TIMEOUT - 1);
   mem_state_t       r_state, w_state_nxt;
   logic [TW-1:0]    r_tcnt, w_tcnt_nxt;
   logic             r_err, w_err_nxt, r_sram_start;
   logic [CNT_W-1:0] r_stall_cnt;
   logic             w_hazard, w_mem_stall, w_branch, w_bubble, w_freeze, w_launch;

   hazard_detect u_hazard_detect (
      .i_id_src1   (bus.id_src1),
      .i_id_src2   (bus.id_src2),
      .i_id_two_src(bus.id_two_src),
      .i_id_valid  (bus.id_valid),
      .i_exe_wb_en (bus.exe_wb_en),
      .i_exe_dest  (bus.exe_dest),
      .i_mem_wb_en (bus.mem_wb_en),
      .i_mem_dest  (bus.mem_dest),
      .o_hazard    (w_hazard)
   );

   // memory-access sequencing: launch, wait for ready or timeout, then one release cycle
   always_comb begin
      w_state_nxt = r_state;
      w_tcnt_nxt  = r_tcnt;
      w_err_nxt   = r_err;
      case (r_state)
         IDLE: if (bus.mem_req) begin
            w_state_nxt = BUSY;
            w_tcnt_nxt  = '0;
         end
         BUSY: if (bus.mem_ready) w_state_nxt = RELEASE;
         else if (r_tcnt == LAST) begin
            w_state_nxt = RELEASE;
            w_err_nxt   = 1'b1;
         end else w_tcnt_nxt = r_tcnt + 1'b1;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_launch    = r_state == IDLE && bus.mem_req;
   assign w_mem_stall = w_launch || r_state == BUSY;
   assign w_branch    = !w_mem_stall && bus.exe_branch_taken;
   assign w_bubble    = !w_mem_stall && !bus.exe_branch_taken && w_hazard;
   assign w_freeze    = w_mem_stall || w_bubble;

   assign bus.pipe_freeze = w_mem_stall;
   assign bus.pc_freeze   = w_freeze;
   assign bus.ifid_freeze = w_freeze;
   assign bus.idex_bubble = w_bubble;
   assign bus.ifid_flush  = w_branch;
   assign bus.idex_flush  = w_branch;
   assign bus.sram_start  = r_sram_start;
   assign bus.mem_err     = r_err;
   assign bus.stall_cnt   = r_stall_cnt;

   // FSM state, timeout counter, sticky error and the first-BUSY-cycle start pulse
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state      <= IDLE;
         r_tcnt       <= '0;
         r_err        <= 1'b0;
         r_sram_start <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_tcnt       <= w_tcnt_nxt;
         r_err        <= w_err_nxt;
         r_sram_start <= w_launch;
      end

   // saturating count of cycles with the PC held
   always_ff @(posedge clk or posedge rst)
      if (rst) r_stall_cnt <= '0;
      else if (w_freeze && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage ARM pipeline. It generates freeze, bubble and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers from three sources: RAW data hazards (no forwarding), taken branches resolved in EXE, and multi-cycle SRAM accesses from the MEM stage. SRAM accesses are sequenced by an internal FSM with a timeout. A saturating stall-cycle counter supports performance debug.

## Interface
- MEM_TIMEOUT, 64: max BUSY cycles waiting for mem_ready before abort (≥2)
- CNT_W, 16: width of stall_cnt
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- id_src1, id_src2  in  4 each  source register numbers of the instruction in ID
- id_two_src  in  1  ID instruction reads id_src2 (register operand or store)
- id_valid  in  1  ID holds a real instruction that reads id_src1
- exe_wb_en, mem_wb_en  in  1 each  write-back enable of the EXE / MEM instruction
- exe_dest, mem_dest  in  4 each  destination register of the EXE / MEM instruction
- exe_branch_taken  in  1  EXE instruction is a taken branch
- mem_req  in  1  MEM instruction is a load or store (MEM_R_EN | MEM_W_EN)
- mem_ready  in  1  SRAM access complete; read data valid and held until next sram_start
- pc_freeze, ifid_freeze  out  1 each  hold PC / IF-ID register
- idex_bubble  out  1  load zeros into ID/EX control bits
- ifid_flush, idex_flush  out  1 each  clear IF/ID / ID/EX contents
- pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
- sram_start  out  1  one-cycle pulse launching the SRAM access
- mem_err  out  1  sticky, set on timeout
- stall_cnt  out  CNT_W  cycles with pc_freeze high, saturating

## Operation
- hazard = id_valid & ((exe_wb_en & exe_dest==id_src1) | (mem_wb_en & mem_dest==id_src1) | id_two_src & (same two terms on id_src2)).
- Memory FSM: IDLE, BUSY, RELEASE. Internal timeout counter, width clog2(MEM_TIMEOUT).
- IDLE: mem_req=1 -> BUSY, counter cleared; otherwise stay.
- BUSY: mem_ready=1 -> RELEASE; counter==MEM_TIMEOUT-1 with mem_ready=0 -> set mem_err, RELEASE; otherwise counter+1.
- RELEASE: unconditionally -> IDLE. mem_req is ignored here; it still belongs to the finishing instruction.
- mem_stall = (state==IDLE & mem_req) | state==BUSY. pipe_freeze = mem_stall.
- Priority, highest first: mem_stall, then branch, then hazard.
  - mem_stall=1: pc_freeze=ifid_freeze=1; flushes and idex_bubble forced 0. A branch or hazard held in the frozen pipe is re-evaluated after release.
  - Else exe_branch_taken=1: ifid_flush=idex_flush=1, freezes 0, idex_bubble=0. The hazard is discarded because its instruction is flushed.
  - Else hazard=1: pc_freeze=ifid_freeze=idex_bubble=1.
  - Else all control outputs 0.
- sram_start is registered: 1 in exactly the first BUSY cycle.
- stall_cnt increments on each cycle pc_freeze=1 and holds at all-ones.
- mem_err is cleared only by rst.

## Timing
- Reset, asynchronous: state IDLE, timeout counter 0, sram_start 0, mem_err 0, stall_cnt 0. Combinational outputs follow from state IDLE and current inputs.
- All freeze, flush and bubble outputs are combinational, valid in the same cycle as their inputs, and consumed at the next clk edge.
- Memory access, mem_req seen at cycle T:
  - T: IDLE, pipe_freeze=1.
  - T+1: BUSY, sram_start=1.
  - Cycle with mem_ready=1 (earliest T+1): pipe_freeze=1.
  - Next cycle: RELEASE, pipe_freeze=0; pipe advances and MEM/WB latches the data at its end.
  - Minimum penalty: 2 frozen cycles.
- Back-to-back accesses: the FSM passes through RELEASE then IDLE, and the second access is frozen starting in that IDLE cycle.
- mem_ready while in IDLE or RELEASE is ignored.
- Timeout: mem_err rises on the edge entering RELEASE and stays high.
- rst mid-BUSY: immediate return to IDLE, sram_start dropped, no mem_err.

## Structure
- Shared package pipe_ctrl_pkg: mem FSM state enum (IDLE/BUSY/RELEASE), register-number width constant (4), default MEM_TIMEOUT.
- One natural sub-module: hazard_detect, purely combinational; produces hazard from the ID/EXE/MEM fields.
- The FSM, timeout counter, priority logic and stall_cnt live in the top module.

## Test plan
- id_src1=3, exe_wb_en=1, exe_dest=3, mem_req=0, branch=0 -> pc_freeze=ifid_freeze=idex_bubble=1 same cycle; stall_cnt 0->1.
- Hazard (mem_dest=5=id_src2, id_two_src=1) together with exe_branch_taken=1 -> ifid_flush=idex_flush=1, idex_bubble=0, pc_freeze=0.
- mem_req=1 at T, mem_ready=1 at T+3 -> pipe_freeze 1 for T..T+3 and 0 at T+4; sram_start only at T+1; state IDLE at T+5.
- MEM_TIMEOUT=4, mem_ready held 0 -> BUSY for 4 cycles, mem_err=1 entering RELEASE and stays 1; the next access still runs normally.
- mem_req with exe_branch_taken=1 during BUSY -> no flush while frozen; flush pulses in the RELEASE cycle if the branch is still in EXE.
- rst asserted asynchronously mid-BUSY -> all outputs and stall_cnt 0 immediately; CNT_W=4 with 20 hazard cycles -> stall_cnt saturates at 15.
